// File: rtl/program_loader_if.sv
// Bundle of the program-load stream, imem write port, core control and status
// seen by program_loader. The master modport is the loader side.
interface program_loader_if #(
    parameter int INSTR_W = 9,
    parameter int ADDR_W  = 10
);
    logic               load_valid;
    logic               load_ready;
    logic [INSTR_W-1:0] load_data;
    logic               load_last;

    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    logic               core_rst;
    logic               core_start;
    logic               core_ack;

    logic               busy;
    logic               done;
    logic               timeout;
    logic [ADDR_W:0]    instr_count;
    logic [15:0]        cycle_count;

    modport master (
        input  load_valid, load_data, load_last, core_ack,
        output load_ready, imem_we, imem_addr, imem_wdata,
               core_rst, core_start, busy, done, timeout,
               instr_count, cycle_count
    );

    modport slave (
        output load_valid, load_data, load_last, core_ack,
        input  load_ready, imem_we, imem_addr, imem_wdata,
               core_rst, core_start, busy, done, timeout,
               instr_count, cycle_count
    );
endinterface

// File: rtl/program_loader.sv
// Streams a program into instruction memory, then resets and starts the core,
// waits for its ack and reports done or timeout.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for the first word of a program
// LOAD     | accepting further words, writing imem
// PREP     | one-cycle core reset pulse
// START_HI | core_start held high for START_CYC cycles
// RUN      | counting run cycles, waiting for core_ack
// DONE     | result held; a new beat starts the next program
module program_loader #(
    parameter int INSTR_W   = 9,
    parameter int ADDR_W    = 10,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                reset,
    program_loader_if.master    lb
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int TMR_MAX = (TIMEOUT > START_CYC) ? TIMEOUT : START_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [ADDR_W:0]  LAST_SLOT  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_CYC - 1);
    localparam logic [TMR_W-1:0] RUN_LOAD   = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PREP,
        S_START_HI,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [ADDR_W:0]     instr_count_q, instr_count_d;
    logic [15:0]         cycle_count_q, cycle_count_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [INSTR_W-1:0]  imem_wdata_q, imem_wdata_d;

    logic                load_ready;
    logic                beat;
    logic [15:0]         cycle_inc;

    // Ready is masked during reset so nothing is advertised while aborting.
    assign load_ready = ((state_q == S_IDLE) || (state_q == S_LOAD) ||
                         (state_q == S_DONE)) && !reset;
    assign beat       = lb.load_valid && load_ready;
    assign cycle_inc  = (cycle_count_q == 16'hFFFF) ? cycle_count_q
                                                    : cycle_count_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            tmr_q         <= '0;
            instr_count_q <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            instr_count_q <= instr_count_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        instr_count_d = instr_count_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        timeout_d     = timeout_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (beat) begin
                    done_d        = 1'b0;
                    timeout_d     = 1'b0;
                    cycle_count_d = '0;
                    instr_count_d = (ADDR_W+1)'(1);
                    imem_we_d     = 1'b1;
                    imem_addr_d   = '0;
                    imem_wdata_d  = lb.load_data;
                    state_d       = lb.load_last ? S_PREP : S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    imem_we_d     = 1'b1;
                    imem_addr_d   = instr_count_q[ADDR_W-1:0];
                    imem_wdata_d  = lb.load_data;
                    instr_count_d = instr_count_q + 1'b1;
                    if (lb.load_last) begin
                        state_d = S_PREP;
                    end else if (instr_count_q == LAST_SLOT) begin
                        // Memory full with no end marker: abandon this program.
                        timeout_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_PREP: begin
                tmr_d   = START_LOAD;
                state_d = S_START_HI;
            end
            S_START_HI: begin
                if (tmr_q == '0) begin
                    tmr_d   = RUN_LOAD;
                    state_d = S_RUN;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_RUN: begin
                cycle_count_d = cycle_inc;
                if (lb.core_ack) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (tmr_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign lb.load_ready  = load_ready;
    assign lb.imem_we     = imem_we_q;
    assign lb.imem_addr   = imem_addr_q;
    assign lb.imem_wdata  = imem_wdata_q;
    assign lb.core_rst    = (state_q == S_PREP);
    assign lb.core_start  = (state_q == S_START_HI);
    assign lb.busy        = (state_q == S_LOAD) || (state_q == S_PREP) ||
                            (state_q == S_START_HI) || (state_q == S_RUN);
    assign lb.done        = done_q;
    assign lb.timeout     = timeout_q;
    assign lb.instr_count = instr_count_q;
    assign lb.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, start/ack, timeout, overflow and
// mid-run reset scenarios with hand-computed expectations.
module tb_program_loader;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    program_loader_if #(.INSTR_W(9), .ADDR_W(10)) bus();

    program_loader #(
        .INSTR_W(9), .ADDR_W(10), .START_CYC(2), .TIMEOUT(4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .lb    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        bus.load_data  = '0;
        bus.core_ack   = 1'b0;
    endtask

    // Issue a single-word program and advance to the first RUN cycle.
    task automatic load_one(input logic [8:0] word);
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_data  = word;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [52:0] outs;
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        outs = {bus.load_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                bus.core_rst, bus.core_start, bus.busy, bus.done, bus.timeout,
                bus.instr_count, bus.cycle_count};
        total++;
        if (outs !== 53'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        reset = 1'b0;
        tick();
        total++;
        if (bus.load_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_ready: ready=%b busy=%b want 1 0", bus.load_ready, bus.busy);
        end
    endtask

    task automatic test_load3();
        logic [8:0] words [3];
        words[0] = 9'h1FF;
        words[1] = 9'h000;
        words[2] = 9'h155;
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = words[i];
            bus.load_last  = (i == 2);
            tick();
            total++;
            if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'(i) ||
                bus.imem_wdata !== words[i] || bus.instr_count !== 11'(i + 1) ||
                bus.core_rst !== (i == 2)) begin
                bad++;
                $display("FAIL load3_beat%0d: we=%b addr=%0d data=%h cnt=%0d rst=%b want 1 %0d %h %0d %b",
                         i, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.instr_count,
                         bus.core_rst, i, words[i], i + 1, (i == 2));
            end
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.load_ready !== 1'b0) begin
            bad++;
            $display("FAIL load3_prep: busy=%b ready=%b want 1 0", bus.busy, bus.load_ready);
        end
    endtask

    task automatic test_start_ack();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus.core_start !== 1'b1 || bus.core_rst !== 1'b0 || bus.imem_we !== 1'b0) begin
                bad++;
                $display("FAIL start_hi%0d: start=%b rst=%b we=%b want 1 0 0",
                         i, bus.core_start, bus.core_rst, bus.imem_we);
            end
        end
        tick();
        total++;
        if (bus.core_start !== 1'b0 || bus.busy !== 1'b1 || bus.cycle_count !== 16'd0) begin
            bad++;
            $display("FAIL run_entry: start=%b busy=%b cyc=%0d want 0 1 0",
                     bus.core_start, bus.busy, bus.cycle_count);
        end
        repeat (4) tick();
        total++;
        if (bus.cycle_count !== 16'd4 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL run_cyc4: cyc=%0d done=%b want 4 0", bus.cycle_count, bus.done);
        end
        bus.core_ack = 1'b1;
        tick();
        bus.core_ack = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.cycle_count !== 16'd5 ||
            bus.busy !== 1'b0 || bus.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL ack5: done=%b to=%b cyc=%0d busy=%b ready=%b want 1 0 5 0 1",
                     bus.done, bus.timeout, bus.cycle_count, bus.busy, bus.load_ready);
        end
        bus.core_ack = 1'b1;
        tick();
        tick();
        bus.core_ack = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.cycle_count !== 16'd5 || bus.core_start !== 1'b0) begin
            bad++;
            $display("FAIL done_hold: done=%b cyc=%0d start=%b want 1 5 0",
                     bus.done, bus.cycle_count, bus.core_start);
        end
    endtask

    task automatic test_timeout();
        load_one(9'h0AA);
        total++;
        if (bus.done !== 1'b0 || bus.cycle_count !== 16'd0 || bus.instr_count !== 11'd1) begin
            bad++;
            $display("FAIL to_clear: done=%b cyc=%0d cnt=%0d want 0 0 1",
                     bus.done, bus.cycle_count, bus.instr_count);
        end
        repeat (4095) tick();
        total++;
        if (bus.cycle_count !== 16'd4095 || bus.timeout !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL to_last_run: cyc=%0d to=%b busy=%b want 4095 0 1",
                     bus.cycle_count, bus.timeout, bus.busy);
        end
        tick();
        total++;
        if (bus.timeout !== 1'b1 || bus.done !== 1'b0 || bus.cycle_count !== 16'd4096 ||
            bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL to_hit: to=%b done=%b cyc=%0d busy=%b want 1 0 4096 0",
                     bus.timeout, bus.done, bus.cycle_count, bus.busy);
        end
    endtask

    task automatic test_ack_on_timeout();
        load_one(9'h123);
        repeat (4095) tick();
        bus.core_ack = 1'b1;
        tick();
        bus.core_ack = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.timeout !== 1'b0 || bus.cycle_count !== 16'd4096) begin
            bad++;
            $display("FAIL ack_vs_to: done=%b to=%b cyc=%0d want 1 0 4096",
                     bus.done, bus.timeout, bus.cycle_count);
        end
    endtask

    task automatic test_overflow();
        int nwrites   = 0;
        int addr_errs = 0;
        int starts    = 0;
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            bus.load_data = 9'(i * 7);
            tick();
            if (bus.imem_we === 1'b1) nwrites++;
            if (bus.imem_addr !== 10'(i) || bus.imem_wdata !== 9'(i * 7)) addr_errs++;
            if (bus.core_start !== 1'b0 || bus.core_rst !== 1'b0) starts++;
        end
        bus.load_valid = 1'b0;
        total++;
        if (nwrites != 1024 || addr_errs != 0) begin
            bad++;
            $display("FAIL ovf_writes: writes=%0d addr_errs=%0d want 1024 0", nwrites, addr_errs);
        end
        total++;
        if (bus.timeout !== 1'b1 || bus.done !== 1'b0 || bus.instr_count !== 11'd1024 ||
            bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_state: to=%b done=%b cnt=%0d busy=%b want 1 0 1024 0",
                     bus.timeout, bus.done, bus.instr_count, bus.busy);
        end
        bus.core_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.core_start !== 1'b0 || bus.core_rst !== 1'b0 || bus.imem_we !== 1'b0) starts++;
        end
        bus.core_ack = 1'b0;
        total++;
        if (starts != 0 || bus.done !== 1'b0 || bus.timeout !== 1'b1) begin
            bad++;
            $display("FAIL ovf_no_start: starts=%0d done=%b to=%b want 0 0 1",
                     starts, bus.done, bus.timeout);
        end
    endtask

    task automatic test_reset_run();
        logic [52:0] outs;
        load_one(9'h011);
        bus.load_valid = 1'b1;
        repeat (37) tick();
        total++;
        if (bus.cycle_count !== 16'd37 || bus.load_ready !== 1'b0 || bus.imem_we !== 1'b0) begin
            bad++;
            $display("FAIL run37: cyc=%0d ready=%b we=%b want 37 0 0",
                     bus.cycle_count, bus.load_ready, bus.imem_we);
        end
        bus.load_valid = 1'b0;
        reset = 1'b1;
        tick();
        outs = {bus.load_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                bus.core_rst, bus.core_start, bus.busy, bus.done, bus.timeout,
                bus.instr_count, bus.cycle_count};
        total++;
        if (outs !== 53'd0) begin
            bad++;
            $display("FAIL run_reset: got %h want 0", outs);
        end
        reset = 1'b0;
        tick();
        bus.load_valid = 1'b1;
        bus.load_last  = 1'b1;
        bus.load_data  = 9'h0AB;
        tick();
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        total++;
        if (bus.imem_we !== 1'b1 || bus.imem_addr !== 10'd0 || bus.imem_wdata !== 9'h0AB ||
            bus.instr_count !== 11'd1 || bus.core_rst !== 1'b1) begin
            bad++;
            $display("FAIL reload: we=%b addr=%0d data=%h cnt=%0d rst=%b want 1 0 0ab 1 1",
                     bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.instr_count, bus.core_rst);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load3();
        test_start_ack();
        test_timeout();
        test_ack_on_timeout();
        test_overflow();
        test_reset_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
